sha256_chain_core: RTL and testbench
====================================

Name: sha256_chain_core

Overview:
- Multi-block SHA-256 compression engine with digest chaining, so messages longer than one 512-bit block can be hashed.
- Successor to the single-block hash core. Adds a parametrised unroll, valid/ready handshakes on both sides, and first/last block framing.
- Sits in the Hash160 datapath between the message padder and the RIPEMD-160 stage.
- The caller supplies padded blocks. The core keeps the running chaining value internally.

Parameters:
- UNROLL, 1, rounds computed per clock. Legal values are 1, 2, 4, 8. Any other value is an elaboration error.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  block[] and the frame flags are valid.
- in_ready  out  1  core can accept a block.
- block  in  512  padded message block; word 0 is in bits [511:480].
- first  in  1  block starts a new message; chain from the IV.
- last  in  1  block ends the message; produce the digest.
- out_valid  out  1  digest valid.
- out_ready  in  1  consumer accepts the digest.
- digest  out  256  final hash; word A is in bits [255:224].
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, round counter=0, chain register H=SHA-256 IV, working registers=0, W stack=0.
  - digest=0, out_valid=0, in_ready=0 while rst is high, in_ready=1 after release, busy=0.
- Definitions: N = 64/UNROLL. The handshake is accepted when in_valid & in_ready at a rising edge T.
- in_ready = (state==IDLE). in_valid is ignored in every other state; no state change results.
- States: IDLE -> ROUND -> FINAL -> (OUT | IDLE).
- IDLE, at the accept edge T:
  - a..h <= IV if first=1, else H.
  - W stack <= block. last is latched. cnt <= 0. state -> ROUND.
- ROUND:
  - Each edge applies UNROLL chained round functions using K[cnt*UNROLL+i] and W[cnt*UNROLL+i].
  - The schedule produces UNROLL new W words per edge: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32.
  - After the N-th ROUND edge (edge T+N), state -> FINAL.
- FINAL, at edge T+N+1:
  - H <= base + {a..h}, where base is the value loaded at T (IV or H). Each 32-bit lane is added mod 2^32 independently; no carry passes between lanes.
  - If the latched last=1: digest <= new H, out_valid <= 1, state -> OUT.
  - If the latched last=0: state -> IDLE with no output. H holds the chaining value for the next block.
- Latency: accept edge to out_valid high is N+1 cycles (65 for UNROLL=1, 9 for UNROLL=8). Throughput is one block per N+2 cycles under no backpressure.
- OUT:
  - digest and out_valid are held stable until out_valid & out_ready. On that edge out_valid <= 0 and state -> IDLE.
  - digest keeps its last value afterwards. in_ready stays 0 while in OUT.
- first=1 on any block discards the prior chain, including a chain left mid-message.
- first=0 straight after reset chains from the IV, because H was reset to the IV.
- first=1 and last=1 together form a single-block message.
- rst asserted mid-ROUND, mid-FINAL or in OUT aborts the operation immediately: all reset values apply, and no digest is produced for the aborted message.
- K constants come from a combinational ROM indexed by round number. No shifting K register.

Optional Feature:
- Macro SHA256_CHAIN_SHA224_EN.
- When defined:
  - Extra input port mode224 (1 bit), sampled at the accept edge together with first.
  - first=1 & mode224=1 loads the SHA-224 IV (c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4).
  - On a last block of a 224-bit message, digest[31:0] is forced to 0 and the 224-bit result is in digest[255:32].
  - The mode is latched per message; blocks with first=0 inherit it.
- When not defined: no mode224 port, and the core is always SHA-256.

Test Plan:
- "abc" (block 61626380, zeros, last word 00000018), first=last=1, UNROLL=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; out_valid rises exactly 65 cycles after accept.
- Empty message (80000000, then zeros), UNROLL=8 -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; latency 9 cycles.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - block 1 sent with first=1, last=0 -> no out_valid.
  - block 2 sent with first=0, last=1 -> digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Backpressure: out_ready held 0 for 20 cycles after the "abc" result -> digest stable and in_ready=0 throughout; a new in_valid during this window is ignored. out_ready=1 -> IDLE next cycle.
- Reset mid-operation: rst pulsed at round 30 of block 1 of the two-block message -> out_valid=0, in_ready=1 after release. Then "abc" with first=0, last=1 -> the "abc" digest above, proving the chain was reset to the IV.
- With SHA256_CHAIN_SHA224_EN defined: "abc" with mode224=1 -> digest[255:32] = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, and digest[31:0] = 0.

Source files
------------

// File: rtl/sha256_chain_core.sv
// Multi-block SHA-256 compression engine with internal chaining value and UNROLL rounds per clock.
// Optional SHA-224 support is enabled by defining SHA256_CHAIN_SHA224_EN.
module sha256_chain_core #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block,
    input  logic         first,
    input  logic         last,
`ifdef SHA256_CHAIN_SHA224_EN
    input  logic         mode224,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] digest,
    output logic         busy
);
    localparam int        N        = 64 / UNROLL;
    localparam logic [5:0] CNT_LAST = 6'(N - 1);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
        $error("sha256_chain_core: UNROLL must be 1, 2, 4 or 8");
    end

    localparam logic [7:0][31:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
`ifdef SHA256_CHAIN_SHA224_EN
    localparam logic [7:0][31:0] IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                          32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
`endif

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2, OUT = 2'd3} state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Working registers live in a packed vector with a in lane 7 down to h in lane 0.
    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [7:0][31:0]   h_q, h_d, v_q, v_d, v_rnd_s, base_s, h_sum_s;
    logic [15:0][31:0]  w_q, w_d, w_rnd_s;
    logic               last_q, last_d, mode_q, mode_d;
    logic [255:0]       digest_q, digest_d;
    logic               out_valid_q, out_valid_d, in_ready_q, in_ready_d, busy_q, busy_d;
    logic [5:0]         rnd_s;
    logic [31:0]        t1_s, t2_s, nw_s;

    // UNROLL chained rounds plus message schedule advance for one ROUND edge.
    always_comb begin
        v_rnd_s = v_q;
        w_rnd_s = w_q;
        rnd_s   = 6'd0;
        t1_s    = 32'd0;
        t2_s    = 32'd0;
        nw_s    = 32'd0;
        for (int i = 0; i < UNROLL; i++) begin
            rnd_s   = cnt_q * 6'(UNROLL) + 6'(i);
            t1_s    = v_rnd_s[0] + bsig1(v_rnd_s[3]) + ((v_rnd_s[3] & v_rnd_s[2]) ^ (~v_rnd_s[3] & v_rnd_s[1]))
                      + K_TAB[rnd_s] + w_rnd_s[15];
            t2_s    = bsig0(v_rnd_s[7]) + ((v_rnd_s[7] & v_rnd_s[6]) ^ (v_rnd_s[7] & v_rnd_s[5]) ^ (v_rnd_s[6] & v_rnd_s[5]));
            nw_s    = ssig1(w_rnd_s[1]) + w_rnd_s[6] + ssig0(w_rnd_s[14]) + w_rnd_s[15];
            v_rnd_s = {t1_s + t2_s, v_rnd_s[7:5], v_rnd_s[4] + t1_s, v_rnd_s[3:1]};
            w_rnd_s = {w_rnd_s[14:0], nw_s};
        end
    end

    // Next-state and output logic of the block FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        h_d         = h_q;
        v_d         = v_q;
        w_d         = w_q;
        last_d      = last_q;
        mode_d      = mode_q;
        digest_d    = digest_q;
        out_valid_d = out_valid_q;
        base_s      = h_q;
        h_sum_s     = h_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    if (first) begin
`ifdef SHA256_CHAIN_SHA224_EN
                        mode_d = mode224;
                        base_s = mode224 ? IV224 : IV256;
`else
                        mode_d = 1'b0;
                        base_s = IV256;
`endif
                    end else begin
                        base_s = h_q;
                    end
                    h_d     = base_s;
                    v_d     = base_s;
                    w_d     = block;
                    last_d  = last;
                    cnt_d   = 6'd0;
                    state_d = ROUND;
                end else begin
                    state_d = IDLE;
                end
            end
            ROUND: begin
                v_d   = v_rnd_s;
                w_d   = w_rnd_s;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = FINAL;
                end else begin
                    state_d = ROUND;
                end
            end
            FINAL: begin
                for (int j = 0; j < 8; j++) begin
                    h_sum_s[j] = h_q[j] + v_q[j];
                end
                h_d = h_sum_s;
                if (last_q) begin
                    digest_d = h_sum_s;
                    if (mode_q) begin
                        digest_d[31:0] = 32'd0;
                    end else begin
                        digest_d[31:0] = h_sum_s[0];
                    end
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and datapath registers; in_ready stays low while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            h_q         <= IV256;
            v_q         <= '0;
            w_q         <= '0;
            last_q      <= 1'b0;
            mode_q      <= 1'b0;
            digest_q    <= 256'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            h_q         <= h_d;
            v_q         <= v_d;
            w_q         <= w_d;
            last_q      <= last_d;
            mode_q      <= mode_d;
            digest_q    <= digest_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign digest    = digest_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_sha256_chain_core.sv
// Scoreboard bench for sha256_chain_core: UNROLL=1 and UNROLL=8 instances, known SHA-256 vectors.
module tb_sha256_chain_core;
    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO1_BLK  = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
    localparam logic [511:0] TWO2_BLK  = {480'h0, 32'h000001c0};
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, first = 1'b0, last = 1'b0, out_ready = 1'b1;
    logic [511:0] block = '0;
    logic         in_ready, out_valid, busy;
    logic [255:0] digest;
    logic         in_valid8 = 1'b0, first8 = 1'b0, last8 = 1'b0, out_ready8 = 1'b1;
    logic [511:0] block8 = '0;
    logic         in_ready8, out_valid8, busy8;
    logic [255:0] digest8;
`ifdef SHA256_CHAIN_SHA224_EN
    logic         mode224 = 1'b0;
`endif

    int           vectors = 0;
    int           miscompares = 0;
    logic [255:0] exp_q[$];
    logic [255:0] exp_d;

    always #5 clk = ~clk;

    sha256_chain_core #(.UNROLL(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .block(block),
        .first(first), .last(last),
`ifdef SHA256_CHAIN_SHA224_EN
        .mode224(mode224),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .digest(digest), .busy(busy));

    sha256_chain_core #(.UNROLL(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .block(block8),
        .first(first8), .last(last8),
`ifdef SHA256_CHAIN_SHA224_EN
        .mode224(1'b0),
`endif
        .out_valid(out_valid8), .out_ready(out_ready8), .digest(digest8), .busy(busy8));

    task automatic drive_block(input logic [511:0] b, input logic f, input logic l);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1; block = b; first = f; last = l;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc, output bit to);
        cyc = 0; to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (out_valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic pop_exp();
        if (exp_q.size() != 0) exp_d = exp_q.pop_front();
        else exp_d = '1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || digest !== 256'd0) begin
            miscompares++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b digest=%h, required 0 0 0 0", in_ready, out_valid, busy, digest);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_abc();
        int cyc; bit to;
        out_ready = 1'b1;
        exp_q.push_back(ABC_DIG);
        drive_block(ABC_BLK, 1'b1, 1'b1);
        vectors++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abc_accept: in_ready=%b busy=%b, required 0 1", in_ready, busy);
        end
        wait_out(cyc, to);
        vectors++;
        if (to || cyc != 65) begin
            miscompares++;
            $display("FAIL abc_latency: got %0d cycles (timeout=%0d), required 65", cyc, to);
        end
        pop_exp();
        vectors++;
        if (digest !== exp_d) begin
            miscompares++;
            $display("FAIL abc_digest: got %h required %h", digest, exp_d);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || digest !== ABC_DIG) begin
            miscompares++;
            $display("FAIL abc_release: out_valid=%b in_ready=%b digest=%h, required 0 1 held", out_valid, in_ready, digest);
        end
    endtask

    task automatic test_backpressure();
        int cyc; bit to; int bad = 0;
        out_ready = 1'b0;
        exp_q.push_back(ABC_DIG);
        drive_block(ABC_BLK, 1'b1, 1'b1);
        wait_out(cyc, to);
        pop_exp();
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                in_valid = 1'b1; block = EMPTY_BLK; first = 1'b1; last = 1'b1;
            end
            if (i == 10) in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (digest !== exp_d || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        vectors++;
        if (to || bad != 0) begin
            miscompares++;
            $display("FAIL bp_hold: %0d unstable cycles (timeout=%0d), digest=%h required %h", bad, to, digest, exp_d);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || digest !== exp_d) begin
            miscompares++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_two_block();
        int cyc; bit to; bit seen = 1'b0;
        drive_block(TWO1_BLK, 1'b1, 1'b0);
        repeat (70) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL two_block_mid: out_valid seen=%b in_ready=%b, required 0 1", seen, in_ready);
        end
        exp_q.push_back(TWO_DIG);
        drive_block(TWO2_BLK, 1'b0, 1'b1);
        wait_out(cyc, to);
        pop_exp();
        vectors++;
        if (to || digest !== exp_d) begin
            miscompares++;
            $display("FAIL two_block_digest: got %h required %h (timeout=%0d)", digest, exp_d, to);
        end
    endtask

    task automatic test_first_discards();
        int cyc; bit to;
        drive_block(TWO1_BLK, 1'b1, 1'b0);
        exp_q.push_back(ABC_DIG);
        drive_block(ABC_BLK, 1'b1, 1'b1);
        wait_out(cyc, to);
        pop_exp();
        vectors++;
        if (to || digest !== exp_d) begin
            miscompares++;
            $display("FAIL first_discards: got %h required %h (timeout=%0d)", digest, exp_d, to);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit to;
        drive_block(TWO1_BLK, 1'b1, 1'b0);
        repeat (30) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_abort: out_valid=%b busy=%b in_ready=%b, required 0 0 0", out_valid, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        exp_q.push_back(ABC_DIG);
        drive_block(ABC_BLK, 1'b0, 1'b1);
        wait_out(cyc, to);
        pop_exp();
        vectors++;
        if (to || digest !== exp_d) begin
            miscompares++;
            $display("FAIL reset_mid_chain_iv: got %h required %h (timeout=%0d)", digest, exp_d, to);
        end
    endtask

    task automatic test_unroll8();
        logic [511:0] blks [3] = '{EMPTY_BLK, TWO1_BLK, TWO2_BLK};
        logic         fs [3] = '{1'b1, 1'b1, 1'b0};
        logic         ls [3] = '{1'b1, 1'b0, 1'b1};
        exp_q.push_back(EMPTY_DIG);
        exp_q.push_back(TWO_DIG);
        for (int k = 0; k < 3; k++) begin
            int cyc = 0; int guard = 0;
            @(negedge clk);
            while (!in_ready8 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            in_valid8 = 1'b1; block8 = blks[k]; first8 = fs[k]; last8 = ls[k];
            @(posedge clk);
            #1 in_valid8 = 1'b0;
            if (ls[k]) begin
                for (int i = 0; i < 50; i++) begin
                    @(posedge clk);
                    cyc++;
                    @(negedge clk);
                    if (out_valid8) break;
                end
                pop_exp();
                vectors++;
                if (!out_valid8 || digest8 !== exp_d) begin
                    miscompares++;
                    $display("FAIL unroll8_digest_%0d: got %h required %h", k, digest8, exp_d);
                end
                if (k == 0) begin
                    vectors++;
                    if (cyc != 9) begin
                        miscompares++;
                        $display("FAIL unroll8_latency: got %0d cycles required 9", cyc);
                    end
                end
            end
        end
    endtask

`ifdef SHA256_CHAIN_SHA224_EN
    task automatic test_sha224();
        int cyc; bit to;
        mode224 = 1'b1;
        exp_q.push_back(256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000);
        drive_block(ABC_BLK, 1'b1, 1'b1);
        mode224 = 1'b0;
        wait_out(cyc, to);
        pop_exp();
        vectors++;
        if (to || digest !== exp_d) begin
            miscompares++;
            $display("FAIL sha224_digest: got %h required %h (timeout=%0d)", digest, exp_d, to);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_abc();
        test_backpressure();
        test_two_block();
        test_first_discards();
        test_reset_mid();
        test_unroll8();
`ifdef SHA256_CHAIN_SHA224_EN
        test_sha224();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
